maxnet_iterator: RTL and testbench

- Downstream consumer of the 16-entry MaxNet weight buffer (W0..W15, row-major 4x4 matrix, Wij at index 4*i+j).
- Iterates the 4-neuron MaxNet update a_i(t+1) = ReLU(sum_j Wij*a_j(t)) until at most one activation is nonzero.
- Reports the winning neuron index, with a start/done handshake toward the top-level controller.

---
 rtl/maxnet_iterator.sv | 142 ++++++++++++++
 tb/tb_maxnet_iterator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/maxnet_iterator.sv
// 4-neuron MaxNet winner-take-all iterator with a start/done handshake.
// Optional: MAXNET_TIE_BREAK_EN reports the lowest nonzero neuron as winner on timeout.
module maxnet_iterator #(
  parameter int WIDTH    = 5,
  parameter int FRAC     = 3,
  parameter int MAX_ITER = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] W0,
  input  logic [WIDTH-1:0] W1,
  input  logic [WIDTH-1:0] W2,
  input  logic [WIDTH-1:0] W3,
  input  logic [WIDTH-1:0] W4,
  input  logic [WIDTH-1:0] W5,
  input  logic [WIDTH-1:0] W6,
  input  logic [WIDTH-1:0] W7,
  input  logic [WIDTH-1:0] W8,
  input  logic [WIDTH-1:0] W9,
  input  logic [WIDTH-1:0] W10,
  input  logic [WIDTH-1:0] W11,
  input  logic [WIDTH-1:0] W12,
  input  logic [WIDTH-1:0] W13,
  input  logic [WIDTH-1:0] W14,
  input  logic [WIDTH-1:0] W15,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             winner_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);

  localparam int ACC_W   = 2 * WIDTH + 2;
  localparam int ACT_MAX = 2 ** (WIDTH - 1) - 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] act      [4];
  logic signed [WIDTH-1:0] act_nxt  [4];
  logic signed [WIDTH-1:0] w        [16];
  logic signed [ACC_W-1:0] acc      [4];
  logic [2:0]              nz_cnt;
  logic [1:0]              low_idx;

  function automatic logic signed [WIDTH-1:0] relu_sat(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] r;
    r = sum >>> FRAC;
    if (r < 0)
      return '0;
    else if (r > ACC_W'(ACT_MAX))
      return WIDTH'(ACT_MAX);
    else
      return WIDTH'(r);
  endfunction

  assign w = '{W0, W1, W2, W3, W4, W5, W6, W7, W8, W9, W10, W11, W12, W13, W14, W15};

  // Full-precision row dot products followed by rescale and ReLU clamp
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc[i] = '0;
      for (int j = 0; j < 4; j++)
        acc[i] = acc[i] + ACC_W'(w[4*i+j]) * ACC_W'(act[j]);
      act_nxt[i] = relu_sat(acc[i]);
    end
  end

  // Scanning downward leaves low_idx at the lowest nonzero neuron
  always_comb begin
    nz_cnt  = '0;
    low_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (act[i] != '0) begin
        nz_cnt  = nz_cnt + 3'd1;
        low_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      for (int i = 0; i < 4; i++) act[i] <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      iter_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            act          <= '{a0, a1, a2, a3};
            iter_count   <= '0;
            timeout      <= 1'b0;
            winner_valid <= 1'b0;
            busy         <= 1'b1;
            state        <= EVAL;
          end
        end
        EVAL: begin
          if (nz_cnt <= 3'd1) begin
            winner       <= low_idx;
            winner_valid <= (nz_cnt == 3'd1);
            done         <= 1'b1;
            state        <= DONE;
          end else if (iter_count == CNT_W'(MAX_ITER)) begin
            timeout      <= 1'b1;
`ifdef MAXNET_TIE_BREAK_EN
            winner       <= low_idx;
            winner_valid <= 1'b1;
`else
            winner       <= '0;
            winner_valid <= 1'b0;
`endif
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            act        <= act_nxt;
            iter_count <= iter_count + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_iterator.sv
// Scoreboard bench for maxnet_iterator: directed MaxNet cases plus random weights/activations.
module tb_maxnet_iterator;

  localparam int MAXI = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] av [4];
  logic [4:0] wv [16];
  logic       busy, done, winner_valid, timeout;
  logic [1:0] winner;
  logic [3:0] iter_count;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {int win; int wvld; int to; int n; int k;} exp_t;
  exp_t sb[$];

  maxnet_iterator #(.WIDTH(5), .FRAC(3), .MAX_ITER(MAXI), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a0(av[0]), .a1(av[1]), .a2(av[2]), .a3(av[3]),
    .W0(wv[0]), .W1(wv[1]), .W2(wv[2]), .W3(wv[3]),
    .W4(wv[4]), .W5(wv[5]), .W6(wv[6]), .W7(wv[7]),
    .W8(wv[8]), .W9(wv[9]), .W10(wv[10]), .W11(wv[11]),
    .W12(wv[12]), .W13(wv[13]), .W14(wv[14]), .W15(wv[15]),
    .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
    .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Reference: iterate the MaxNet rules on integer activations
  function automatic exp_t model();
    exp_t e;
    int a[4], an[4], w[16], acc, r, nz, low;
    for (int k = 0; k < 16; k++) w[k] = int'($signed(wv[k]));
    for (int i = 0; i < 4; i++) a[i] = int'(av[i]);
    e.n = 0; e.to = 0; e.win = 0; e.wvld = 0; e.k = 0;
    forever begin
      nz = 0; low = -1;
      for (int i = 0; i < 4; i++) if (a[i] != 0) begin nz++; if (low < 0) low = i; end
      if (nz <= 1) begin
        e.win = (low < 0) ? 0 : low;
        e.wvld = (nz == 1);
        break;
      end
      if (e.n == MAXI) begin
        e.to = 1;
`ifdef MAXNET_TIE_BREAK_EN
        e.win = low; e.wvld = 1;
`else
        e.win = 0; e.wvld = 0;
`endif
        break;
      end
      for (int i = 0; i < 4; i++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc += w[4*i+j] * a[j];
        r = (acc >= 0) ? acc / 8 : -((-acc + 7) / 8);
        an[i] = (r < 0) ? 0 : (r > 15) ? 15 : r;
      end
      a = an;
      e.n++;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("winner", int'(winner), e.win);
        chk("winner_valid", int'(winner_valid), e.wvld);
        chk("timeout", int'(timeout), e.to);
        chk("iter_count", int'(iter_count), e.n);
        chk("latency", cyc, e.k + e.n + 1);
      end
    end
  end

  task automatic set_inhib();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wv[4*i+j] = (i == j) ? 5'b01000 : 5'b11110;
  endtask

  task automatic set_ident();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wv[4*i+j] = (i == j) ? 5'b01000 : 5'b00000;
  endtask

  task automatic set_a(input int x0, input int x1, input int x2, input int x3);
    av[0] = 5'(x0); av[1] = 5'(x1); av[2] = 5'(x2); av[3] = 5'(x3);
  endtask

  task automatic run(input bit poke);
    exp_t e;
    bit seen;
    @(negedge clk);
    e = model();
    e.k = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = poke && (i == 0) && !done;
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_seen", 0, 1);
      sb.delete();
    end else if (poke) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("busy_after_ignored_start", int'(busy), 0);
      chk("done_after_ignored_start", int'(done), 0);
    end
  endtask

  initial begin
    set_inhib();
    set_a(0, 0, 0, 0);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_winner_valid", int'(winner_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_iter_count", int'(iter_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset asserted mid-run aborts without a done pulse
    @(negedge clk);
    set_a(8, 8, 0, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_iter_count", int'(iter_count), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_winner_valid", int'(winner_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    set_inhib();
    set_a(8, 4, 2, 1);  run(1'b1);
    set_a(0, 0, 9, 0);  run(1'b0);
    set_a(8, 8, 0, 0);  run(1'b1);
    set_a(0, 0, 0, 0);  run(1'b0);
    set_a(0, 3, 0, 7);  run(1'b0);
    set_ident();
    set_a(8, 8, 0, 0);  run(1'b0);
    set_a(0, 5, 5, 5);  run(1'b1);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 16; k++) wv[k] = 5'($urandom_range(0, 31));
      if (t % 2 == 0)
        for (int i = 0; i < 4; i++) wv[5*i] = 5'($urandom_range(6, 15));
      for (int i = 0; i < 4; i++) av[i] = 5'($urandom_range(0, 15));
      run(t % 5 == 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
